// File: rtl/ram_req_arbiter_if.sv
// Requester-side and SDRAM-side signal bundle for ram_req_arbiter.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface ram_req_arbiter_if #(
   parameter int N_REQ      = 2,
   parameter int ADDR_WIDTH = 23,
   parameter int DATA_WIDTH = 16
);
   localparam int BW = DATA_WIDTH / 8;

   logic [N_REQ-1:0]            REQ;
   logic [N_REQ*ADDR_WIDTH-1:0] ADDR;
   logic [N_REQ-1:0]            WE;
   logic [N_REQ*DATA_WIDTH-1:0] DIN;
   logic [N_REQ*BW-1:0]         BE;
   logic [N_REQ-1:0]            ACK;
   logic                        ERR;
   logic [DATA_WIDTH-1:0]       DOUT;

   logic                        MEM_REQ;
   logic [ADDR_WIDTH-1:0]       MEM_ADDR;
   logic                        MEM_WE;
   logic [DATA_WIDTH-1:0]       MEM_DIN;
   logic [BW-1:0]               MEM_BE;
   logic                        MEM_ACK;
   logic [DATA_WIDTH-1:0]       MEM_DOUT;

   modport slave (
      input  REQ, ADDR, WE, DIN, BE,
      output ACK, ERR, DOUT,
      output MEM_REQ, MEM_ADDR, MEM_WE, MEM_DIN, MEM_BE,
      input  MEM_ACK, MEM_DOUT
   );

   modport master (
      output REQ, ADDR, WE, DIN, BE,
      input  ACK, ERR, DOUT,
      input  MEM_REQ, MEM_ADDR, MEM_WE, MEM_DIN, MEM_BE,
      output MEM_ACK, MEM_DOUT
   );
endinterface

// File: rtl/ram_req_arbiter.sv
// Round-robin arbiter sharing one SDRAM request port among N_REQ requesters,
// with a watchdog that aborts a transaction whose MEM_ACK never arrives.
module ram_req_arbiter #(
   parameter int N_REQ      = 2,
   parameter int ADDR_WIDTH = 23,
   parameter int DATA_WIDTH = 16,
   parameter int TIMEOUT    = 63
) (
   input  logic               CLK,
   input  logic               RESET_n,
   ram_req_arbiter_if.slave   bus
);
   localparam int BW = DATA_WIDTH / 8;
   localparam int SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next;

   logic [SW-1:0]         r_rr;
   logic [SW-1:0]         r_sel;
   logic [SW-1:0]         w_win;
   logic [SW:0]           w_idx;
   logic                  w_any;
   logic [SW-1:0]         w_rr_nxt;

   logic [WW-1:0]         r_wdog;
   logic                  r_abort;
   logic                  w_tmo;

   logic                  r_mem_req;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic                  r_mem_we;
   logic [DATA_WIDTH-1:0] r_mem_din;
   logic [BW-1:0]         r_mem_be;
   logic [DATA_WIDTH-1:0] r_dout;

   logic [N_REQ-1:0]      w_ack;
   logic                  w_err;

   // Scan downward over offsets so the smallest offset from r_rr wins.
   always_comb begin
      w_any = |bus.REQ;
      w_win = r_rr;
      w_idx = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_idx = {1'b0, r_rr} + (SW+1)'(k);
         if (w_idx >= (SW+1)'(N_REQ)) begin
            w_idx = w_idx - (SW+1)'(N_REQ);
         end
         if (bus.REQ[w_idx[SW-1:0]]) begin
            w_win = w_idx[SW-1:0];
         end
      end
   end

   assign w_tmo    = (r_wdog == WW'(TIMEOUT - 1));
   assign w_rr_nxt = (r_sel == SW'(N_REQ - 1)) ? '0 : r_sel + SW'(1);

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.MEM_ACK || w_tmo) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_comb begin
      w_ack = '0;
      w_err = 1'b0;
      if (r_state == S_DONE) begin
         w_ack[r_sel] = 1'b1;
         w_err        = r_abort;
      end
   end

   // MEM_ACK is checked first so it beats a watchdog expiry in the same cycle.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         r_rr       <= '0;
         r_sel      <= '0;
         r_wdog     <= '0;
         r_abort    <= 1'b0;
         r_mem_req  <= 1'b0;
         r_mem_addr <= '0;
         r_mem_we   <= 1'b0;
         r_mem_din  <= '0;
         r_mem_be   <= '0;
         r_dout     <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_sel      <= w_win;
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= bus.ADDR[w_win*ADDR_WIDTH +: ADDR_WIDTH];
                  r_mem_we   <= bus.WE[w_win];
                  r_mem_din  <= bus.DIN[w_win*DATA_WIDTH +: DATA_WIDTH];
                  r_mem_be   <= bus.BE[w_win*BW +: BW];
                  r_wdog     <= '0;
               end
            end
            S_WAIT: begin
               if (bus.MEM_ACK) begin
                  r_mem_req <= 1'b0;
                  if (!r_mem_we) begin
                     r_dout <= bus.MEM_DOUT;
                  end
               end else if (w_tmo) begin
                  r_mem_req <= 1'b0;
                  r_abort   <= 1'b1;
               end else begin
                  r_wdog <= r_wdog + WW'(1);
               end
            end
            S_DONE: begin
               r_rr    <= w_rr_nxt;
               r_abort <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.ACK      = w_ack;
   assign bus.ERR      = w_err;
   assign bus.DOUT     = r_dout;
   assign bus.MEM_REQ  = r_mem_req;
   assign bus.MEM_ADDR = r_mem_addr;
   assign bus.MEM_WE   = r_mem_we;
   assign bus.MEM_DIN  = r_mem_din;
   assign bus.MEM_BE   = r_mem_be;
endmodule

// File: tb/tb_ram_req_arbiter.sv
// Scoreboard bench for ram_req_arbiter: expected grants are queued as requests
// are driven and popped when the arbiter pulses ACK.
module tb_ram_req_arbiter;
   localparam int N  = 2;
   localparam int AW = 23;
   localparam int DW = 16;
   localparam int TO = 63;

   typedef struct {
      int          idx;
      logic        we;
      logic [22:0] addr;
      logic [15:0] din;
      logic [1:0]  be;
      logic        err;
      logic [15:0] dout;
      int          mcyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_cmp;
   int   n_bad;
   exp_t sb[$];

   logic [22:0] q_addr[N];
   logic        q_we[N];
   logic [15:0] q_din[N];
   logic [1:0]  q_be[N];
   int          tb_rr;
   logic [15:0] m_dout;

   int mem_delay;
   bit mem_never;

   ram_req_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

   ram_req_arbiter #(
      .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
   ) dut (
      .CLK(clk),
      .RESET_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] mem_data(input logic [22:0] a);
      return (a == 23'h000123) ? 16'hBEEF : (a[15:0] ^ 16'h5A5A);
   endfunction

   task automatic set_req(input int i, input logic [22:0] a, input logic we,
                          input logic [15:0] d, input logic [1:0] be);
      q_addr[i] = a;
      q_we[i]   = we;
      q_din[i]  = d;
      q_be[i]   = be;
      bus.ADDR[i*AW +: AW] = a;
      bus.WE[i]            = we;
      bus.DIN[i*DW +: DW]  = d;
      bus.BE[i*2 +: 2]     = be;
   endtask

   task automatic push_exp(input int i, input logic err, input int mcyc);
      exp_t e;
      e.idx  = i;
      e.we   = q_we[i];
      e.addr = q_addr[i];
      e.din  = q_din[i];
      e.be   = q_be[i];
      e.err  = err;
      if (!err && !q_we[i]) m_dout = mem_data(q_addr[i]);
      e.dout = m_dout;
      e.mcyc = mcyc;
      sb.push_back(e);
      tb_rr = (i + 1) % N;
   endtask

   task automatic wait_ack(input logic [1:0] mask, input logic [1:0] drop,
                           output int t);
      t = -1;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (|(bus.ACK & mask)) begin
            bus.REQ = bus.REQ & ~drop;
            t = cyc;
            return;
         end
      end
      chk("ack_wait", 64'(bus.ACK & mask), 64'(mask));
   endtask

   // Memory stub: pulses MEM_ACK so it is sampled mem_delay+1 edges after MEM_REQ rises.
   initial begin
      int rcnt;
      rcnt = 0;
      bus.MEM_ACK  = 1'b0;
      bus.MEM_DOUT = '0;
      forever begin
         @(negedge clk);
         bus.MEM_ACK = 1'b0;
         if (rst_n && bus.MEM_REQ) begin
            if (!mem_never && rcnt == mem_delay) begin
               bus.MEM_ACK  = 1'b1;
               bus.MEM_DOUT = mem_data(bus.MEM_ADDR);
            end
            rcnt++;
         end else begin
            rcnt = 0;
         end
      end
   end

   initial begin
      logic prev;
      int   hi;
      exp_t e;
      prev = 1'b0;
      hi   = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev = 1'b0;
            hi   = 0;
         end else begin
            if (bus.MEM_REQ && !prev) begin
               hi = 1;
               if (sb.size() == 0) begin
                  chk("mem_req_unexp", 64'(bus.MEM_REQ), 64'd0);
               end else begin
                  e = sb[0];
                  chk("mem_addr", 64'(bus.MEM_ADDR), 64'(e.addr));
                  chk("mem_we", 64'(bus.MEM_WE), 64'(e.we));
                  if (e.we) begin
                     chk("mem_din", 64'(bus.MEM_DIN), 64'(e.din));
                     chk("mem_be", 64'(bus.MEM_BE), 64'(e.be));
                  end
               end
            end else if (bus.MEM_REQ) begin
               hi++;
            end else if (prev && sb.size() > 0) begin
               chk("mem_req_cycles", 64'(hi), 64'(sb[0].mcyc));
            end
            prev = bus.MEM_REQ;
            if (bus.ACK != '0) begin
               if (sb.size() == 0) begin
                  chk("ack_unexp", 64'(bus.ACK), 64'd0);
               end else begin
                  e = sb.pop_front();
                  chk("ack_grant", 64'(bus.ACK), 64'(1 << e.idx));
                  chk("err", 64'(bus.ERR), 64'(e.err));
                  chk("dout", 64'(bus.DOUT), 64'(e.dout));
               end
            end else begin
               chk("err_idle", 64'(bus.ERR), 64'd0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got cyc=%0d expected finish", cyc);
      $fatal(1, "run did not finish");
   end

   initial begin
      int t_req;
      int t_ack;
      n_cmp     = 0;
      n_bad     = 0;
      tb_rr     = 0;
      m_dout    = '0;
      mem_delay = 1;
      mem_never = 1'b0;
      rst_n     = 1'b0;
      bus.REQ   = '0;
      bus.ADDR  = '0;
      bus.WE    = '0;
      bus.DIN   = '0;
      bus.BE    = '0;
      repeat (3) @(negedge clk);
      chk("rst_ack", 64'(bus.ACK), 64'd0);
      chk("rst_err", 64'(bus.ERR), 64'd0);
      chk("rst_dout", 64'(bus.DOUT), 64'd0);
      chk("rst_mem_req", 64'(bus.MEM_REQ), 64'd0);
      chk("rst_mem_addr", 64'(bus.MEM_ADDR), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // single read, MEM_ACK 3 cycles after MEM_REQ
      mem_delay = 3;
      set_req(0, 23'h000123, 1'b0, 16'h0000, 2'b11);
      push_exp(0, 1'b0, 4);
      bus.REQ[0] = 1'b1;
      t_req = cyc;
      wait_ack(2'b01, 2'b01, t_ack);
      chk("read_latency", 64'(t_ack - t_req), 64'd5);
      repeat (2) @(negedge clk);

      // write keeps DOUT
      set_req(1, 23'h000456, 1'b1, 16'h55AA, 2'b10);
      push_exp(1, 1'b0, 4);
      bus.REQ[1] = 1'b1;
      wait_ack(2'b10, 2'b10, t_ack);
      repeat (2) @(negedge clk);

      // contention, both held for six grants
      mem_delay = 1;
      set_req(0, 23'h000100, 1'b0, 16'h0000, 2'b11);
      set_req(1, 23'h000200, 1'b0, 16'h0000, 2'b11);
      for (int i = 0; i < 6; i++) push_exp(tb_rr, 1'b0, 2);
      bus.REQ = 2'b11;
      for (int i = 0; i < 6; i++) begin
         wait_ack(2'b11, (i == 5) ? 2'b11 : 2'b00, t_ack);
      end
      repeat (2) @(negedge clk);

      // watchdog abort, then a normal request
      mem_never = 1'b1;
      set_req(0, 23'h000777, 1'b0, 16'h0000, 2'b11);
      push_exp(0, 1'b1, TO);
      bus.REQ[0] = 1'b1;
      wait_ack(2'b01, 2'b01, t_ack);
      mem_never = 1'b0;
      mem_delay = 2;
      repeat (2) @(negedge clk);
      set_req(1, 23'h000321, 1'b0, 16'h0000, 2'b11);
      push_exp(1, 1'b0, 3);
      bus.REQ[1] = 1'b1;
      wait_ack(2'b10, 2'b10, t_ack);
      repeat (2) @(negedge clk);

      // MEM_ACK on the watchdog's last cycle
      mem_delay = TO - 1;
      set_req(0, 23'h000ABC, 1'b0, 16'h0000, 2'b11);
      push_exp(0, 1'b0, TO);
      bus.REQ[0] = 1'b1;
      wait_ack(2'b01, 2'b01, t_ack);
      repeat (2) @(negedge clk);

      // REQ dropped while in WAIT_ACK
      mem_delay = 5;
      set_req(1, 23'h000DEF, 1'b0, 16'h0000, 2'b11);
      push_exp(1, 1'b0, 6);
      bus.REQ[1] = 1'b1;
      repeat (3) @(negedge clk);
      bus.REQ[1] = 1'b0;
      wait_ack(2'b10, 2'b00, t_ack);
      repeat (3) @(negedge clk);

      // move pointer to 1, then reset mid WAIT_ACK
      mem_delay = 1;
      set_req(0, 23'h000100, 1'b0, 16'h0000, 2'b11);
      push_exp(0, 1'b0, 2);
      bus.REQ[0] = 1'b1;
      wait_ack(2'b01, 2'b01, t_ack);
      repeat (2) @(negedge clk);
      mem_never = 1'b1;
      set_req(1, 23'h000555, 1'b0, 16'h0000, 2'b11);
      push_exp(1, 1'b1, TO);
      bus.REQ[1] = 1'b1;
      repeat (6) @(negedge clk);
      chk("pre_rst_mem_req", 64'(bus.MEM_REQ), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_mem_req", 64'(bus.MEM_REQ), 64'd0);
      chk("midrst_ack", 64'(bus.ACK), 64'd0);
      chk("midrst_dout", 64'(bus.DOUT), 64'd0);
      sb.delete();
      bus.REQ   = '0;
      tb_rr     = 0;
      m_dout    = '0;
      mem_never = 1'b0;
      mem_delay = 1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      set_req(0, 23'h000100, 1'b0, 16'h0000, 2'b11);
      set_req(1, 23'h000200, 1'b0, 16'h0000, 2'b11);
      push_exp(0, 1'b0, 2);
      push_exp(1, 1'b0, 2);
      bus.REQ = 2'b11;
      wait_ack(2'b01, 2'b01, t_ack);
      wait_ack(2'b10, 2'b10, t_ack);
      repeat (4) @(negedge clk);

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
